// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and pipe_ctrl.
// The master side raises the requests, and the slave side (pipe_ctrl) drives the stall/flush controls.
interface pipe_ctrl_if #(
  parameter int MC_CNT_W = 5
);
  logic                id_stallreq;
  logic                ex_mc_start;
  logic [MC_CNT_W-1:0] ex_mc_cycles;
  logic                mem_stallreq;
  logic                ex_flushreq;
  logic [5:0]          ctrl_stall;
  logic                ctrl_flush;
  logic                ex_mc_done;
  logic [31:0]         perf_stall_cnt;
  logic                mem_timeout;

  modport master (
    output id_stallreq, ex_mc_start, ex_mc_cycles, mem_stallreq, ex_flushreq,
    input  ctrl_stall, ctrl_flush, ex_mc_done, perf_stall_cnt, mem_timeout
  );

  modport slave (
    input  id_stallreq, ex_mc_start, ex_mc_cycles, mem_stallreq, ex_flushreq,
    output ctrl_stall, ctrl_flush, ex_mc_done, perf_stall_cnt, mem_timeout
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller. It merges ID, EX and MEM stall requests with the EX flush and sequences EX multi-cycle ops.
// Optional feature: define PIPE_CTRL_MEM_TIMEOUT_EN to build the sticky MEM-stall timeout detector.
module pipe_ctrl #(
  parameter int MC_CNT_W    = 5,
  parameter int MEM_TIMEOUT = 255
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);
  localparam logic RST_ENABLE = 1'b0;
  localparam int   STALL_BUS  = 6;

  localparam logic [STALL_BUS-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_BUS-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_BUS-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_BUS-1:0] STALL_MEM  = 6'b011111;

  if (MC_CNT_W < 1 || MEM_TIMEOUT < 1) begin : g_param_check
    $error("pipe_ctrl: MC_CNT_W and MEM_TIMEOUT must both be at least 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state, state_next;
  logic [MC_CNT_W-1:0]  cnt, cnt_next;
  logic [STALL_BUS-1:0] stall;
  logic                 flush;
  logic                 done;
  logic                 ex_stall;
  logic [31:0]          perf_cnt;

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall      = STALL_NONE;
    flush      = 1'b0;
    done       = 1'b0;
    ex_stall   = 1'b0;

    if (rst == RST_ENABLE) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else if (bus.ex_flushreq) begin
      flush      = 1'b1;
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ex_mc_start && bus.ex_mc_cycles != '0) begin
            ex_stall = 1'b1;
            if (bus.ex_mc_cycles == MC_CNT_W'(1)) begin
              state_next = DONE;
            end else begin
              cnt_next   = bus.ex_mc_cycles - 1'b1;
              state_next = BUSY;
            end
          end
        end
        BUSY: begin
          // The countdown continues even while a MEM stall hides the EX encoding.
          ex_stall = 1'b1;
          cnt_next = cnt - 1'b1;
          if (cnt == MC_CNT_W'(1)) state_next = DONE;
        end
        DONE: begin
          done = 1'b1;
          if (!bus.mem_stallreq) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase

      if (bus.mem_stallreq)     stall = STALL_MEM;
      else if (ex_stall)        stall = STALL_EX;
      else if (bus.id_stallreq) stall = STALL_ID;
    end
  end

  // NOTE: state registers use non-blocking assignments so that every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state    <= IDLE;
      cnt      <= '0;
      perf_cnt <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (stall != STALL_NONE && perf_cnt != 32'hFFFF_FFFF) perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign bus.ctrl_stall     = stall;
  assign bus.ctrl_flush     = flush;
  assign bus.ex_mc_done     = done;
  assign bus.perf_stall_cnt = perf_cnt;

`ifdef PIPE_CTRL_MEM_TIMEOUT_EN
  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_flag;

  // Counts consecutive MEM-stall cycles. The flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else if (bus.mem_stallreq) begin
      if (to_cnt != TO_W'(MEM_TIMEOUT)) to_cnt <= to_cnt + 1'b1;
      if (to_cnt == TO_W'(MEM_TIMEOUT - 1)) to_flag <= 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end

  assign bus.mem_timeout = to_flag;
`else
  assign bus.mem_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the driver queues hand-computed per-cycle expectations, and the monitor checks them on the falling edge.
module tb_pipe_ctrl;
  localparam int MC_W = 5;
`ifdef PIPE_CTRL_MEM_TIMEOUT_EN
  localparam int T = 1;
`else
  localparam int T = 0;
`endif

  localparam logic [5:0] S0 = 6'b000000;
  localparam logic [5:0] SI = 6'b000111;
  localparam logic [5:0] SE = 6'b001111;
  localparam logic [5:0] SM = 6'b011111;

  typedef struct {
    string      name;
    logic [5:0] stall;
    logic       flush;
    logic       done;
    int         perf;  // -1: not checked this cycle
    int         tmo;   // -1: not checked this cycle
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  pipe_ctrl_if #(.MC_CNT_W(MC_W)) bus ();

  pipe_ctrl #(.MC_CNT_W(MC_W), .MEM_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: the outputs are valid every cycle, so one queued expectation is retired per falling edge.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check({e.name, ".stall"}, 32'(bus.ctrl_stall), 32'(e.stall));
      check({e.name, ".flush"}, 32'(bus.ctrl_flush), 32'(e.flush));
      check({e.name, ".done"},  32'(bus.ex_mc_done), 32'(e.done));
      if (e.perf >= 0) check({e.name, ".perf"}, bus.perf_stall_cnt, 32'(e.perf));
      if (e.tmo  >= 0) check({e.name, ".tmo"},  32'(bus.mem_timeout), 32'(e.tmo));
    end
  end

  task automatic step(input string nm, input bit r, input bit id, input bit mcs, input int n,
                      input bit mem, input bit fl, input logic [5:0] es, input bit ef,
                      input bit ed, input int ep, input int et);
    exp_t e;
    @(posedge clk);
    #1;
    rst              = r;
    bus.id_stallreq  = id;
    bus.ex_mc_start  = mcs;
    bus.ex_mc_cycles = MC_W'(n);
    bus.mem_stallreq = mem;
    bus.ex_flushreq  = fl;
    e.name  = nm;
    e.stall = es;
    e.flush = ef;
    e.done  = ed;
    e.perf  = ep;
    e.tmo   = et;
    sb_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit mem_pat[10]  = '{1, 1, 1, 0, 1, 1, 1, 1, 0, 0};
    int perf_pat[10] = '{0, 1, 2, 3, 3, 4, 5, 6, 7, 7};
    rst = 1'b0;
    bus.id_stallreq = 1'b0; bus.ex_mc_start = 1'b0; bus.ex_mc_cycles = '0;
    bus.mem_stallreq = 1'b0; bus.ex_flushreq = 1'b0;

    // Reset with every request high, then an ID stall on the first free cycle.
    step("rst0",          0, 1, 1, 3, 1, 1, S0, 0, 0, -1, -1);
    step("rst1",          0, 1, 1, 3, 1, 1, S0, 0, 0,  0,  0);
    step("id_first",      1, 1, 0, 0, 0, 0, SI, 0, 0,  0,  0);
    step("id_clear",      1, 0, 0, 0, 0, 0, S0, 0, 0,  1,  0);
    step("mem_over_id",   1, 1, 0, 0, 1, 0, SM, 0, 0,  1,  0);
    step("flush_over_mem",1, 1, 0, 0, 1, 1, S0, 1, 0,  2,  0);
    step("n0_ignored",    1, 0, 1, 0, 0, 0, S0, 0, 0,  2,  0);
    step("n0_ignored2",   1, 0, 1, 0, 0, 0, S0, 0, 0,  2,  0);
    step("ex_over_id",    1, 1, 1, 2, 0, 0, SE, 0, 0,  2,  0);
    step("n2_busy",       1, 1, 1, 2, 0, 0, SE, 0, 0,  3,  0);
    step("n2_done",       1, 0, 1, 2, 0, 0, S0, 0, 1,  4,  0);
    step("n2_idle",       1, 0, 0, 0, 0, 0, S0, 0, 0,  4,  0);

    // N=4 op: four EX stall cycles, then done.
    step("rst_b",         0, 0, 0, 0, 0, 0, S0, 0, 0, -1,  0);
    for (int i = 0; i < 4; i++) step("n4_stall", 1, 0, 1, 4, 0, 0, SE, 0, 0, i, 0);
    step("n4_done",       1, 0, 1, 4, 0, 0, S0, 0, 1,  4,  0);
    step("n4_idle",       1, 0, 0, 0, 0, 0, S0, 0, 0,  4,  0);

    // N=5 op with MEM stall in relative cycles 2..6; done is held through MEM and released in cycle 7.
    step("rst_c",         0, 0, 0, 0, 0, 0, S0, 0, 0, -1,  0);
    step("n5_t0",         1, 0, 1, 5, 0, 0, SE, 0, 0,  0,  0);
    step("n5_t1",         1, 0, 1, 5, 0, 0, SE, 0, 0,  1,  0);
    step("n5_t2",         1, 0, 1, 5, 1, 0, SM, 0, 0,  2,  0);
    step("n5_t3",         1, 0, 1, 5, 1, 0, SM, 0, 0,  3,  0);
    step("n5_t4",         1, 0, 1, 5, 1, 0, SM, 0, 0,  4,  0);
    step("n5_t5",         1, 0, 1, 5, 1, 0, SM, 0, 1,  5,  0);
    step("n5_t6",         1, 0, 1, 5, 1, 0, SM, 0, 1,  6,  T);
    step("n5_t7",         1, 0, 1, 5, 0, 0, S0, 0, 1,  7,  T);
    step("n5_idle_n1",    1, 0, 1, 1, 0, 0, SE, 0, 0,  7,  T);
    step("n1_done",       1, 0, 1, 1, 0, 0, S0, 0, 1,  8,  T);
    step("n1_idle",       1, 0, 0, 0, 0, 0, S0, 0, 0,  8,  T);

    // Flush during BUSY aborts the op, and a later N=1 op completes normally.
    step("rst_d",         0, 0, 0, 0, 0, 0, S0, 0, 0, -1, -1);
    step("n8_t0",         1, 0, 1, 8, 0, 0, SE, 0, 0,  0,  0);
    step("n8_flush",      1, 0, 1, 8, 0, 1, S0, 1, 0,  1,  0);
    for (int i = 0; i < 4; i++) step("n8_aborted", 1, 0, 0, 0, 0, 0, S0, 0, 0, 1, 0);
    step("n1b_stall",     1, 0, 1, 1, 0, 0, SE, 0, 0,  1,  0);
    step("n1b_done",      1, 0, 1, 1, 0, 0, S0, 0, 1,  2,  0);
    step("n1b_idle",      1, 0, 0, 0, 0, 0, S0, 0, 0,  2,  0);
    step("flush_start",   1, 0, 1, 3, 0, 1, S0, 1, 0,  2,  0);
    step("fs_idle0",      1, 0, 0, 0, 0, 0, S0, 0, 0,  2,  0);
    step("fs_idle1",      1, 0, 0, 0, 0, 0, S0, 0, 0,  2,  0);
    step("fd_stall",      1, 0, 1, 1, 0, 0, SE, 0, 0,  2,  0);
    step("flush_done",    1, 0, 1, 1, 0, 1, S0, 1, 0,  3,  0);
    step("fd_idle",       1, 0, 0, 0, 0, 0, S0, 0, 0,  3,  0);

    // Reset in the middle of BUSY: no done afterwards.
    step("rb_stall",      1, 0, 1, 4, 0, 0, SE, 0, 0,  3,  0);
    step("rb_reset",      0, 0, 1, 4, 0, 0, S0, 0, 0,  4,  0);
    for (int i = 0; i < 4; i++) step("rb_after", 1, 0, 0, 0, 0, 0, S0, 0, 0, 0, 0);

    // MEM timeout pattern: high 3, low 1, high 4, then low.
    step("rst_e",         0, 0, 0, 0, 0, 0, S0, 0, 0, -1,  0);
    for (int i = 0; i < 10; i++)
      step("tmo_pat", 1, 0, 0, 0, mem_pat[i], 0, mem_pat[i] ? SM : S0, 0, 0, perf_pat[i], (i >= 8) ? T : 0);

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline stall/flush controller for the five-stage core. It merges stall requests from ID (load-use), EX (multi-cycle mul/div), and MEM (data-memory wait) with the EX flush request. It drives the shared `ctrl_stall` bus sampled by PC, IF_ID, ID_EX, EX_MEM and MEM_WB. It also sequences EX multi-cycle operations with an internal counter/FSM and keeps a stall-cycle performance counter.

## Interface

Parameters:
- MC_CNT_W, 5: width of multi-cycle length field.
- MEM_TIMEOUT, 255: consecutive MEM-stall cycles before timeout flag.

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (`RST_ENABLE` = 1'b0).
- id_stallreq  in  1  load-use hazard from ID.
- ex_mc_start  in  1  EX holds a multi-cycle op; stays high while that op sits in EX.
- ex_mc_cycles  in  MC_CNT_W  stall length N for that op, valid with ex_mc_start.
- mem_stallreq  in  1  data memory not ready.
- ex_flushreq  in  1  exception/redirect from EX; flush all younger stages.
- ctrl_stall  out  `STALL_BUS` (6)  bit0 PC, bit1 IF_ID, bit2 ID_EX, bit3 EX_MEM, bit4 MEM_WB, bit5 reserved (always 0); 1 = `STALL_ENABLE`.
- ctrl_flush  out  1  clear IF_ID/ID_EX/EX_MEM this cycle.
- ex_mc_done  out  1  multi-cycle result valid; EX may advance at end of this cycle.
- perf_stall_cnt  out  32  cycles with any ctrl_stall bit set.
- mem_timeout  out  1  sticky MEM timeout flag.

## Operation

- ctrl_stall, ctrl_flush, ex_mc_done are combinational from inputs and registered state. Pipeline registers sample them at the next edge.
- Stall encodings: MEM 6'b011111; EX 6'b001111; ID 6'b000111; none 6'b000000. A register inserts a bubble when its own bit is 1 and the next bit is 0.
- Priority, highest first: reset, ex_flushreq, mem_stallreq, EX multi-cycle, id_stallreq.
- Flush:
  - ctrl_flush = 1 and ctrl_stall = 0 regardless of other requests.
  - FSM goes to IDLE and the counter clears, aborting any multi-cycle op.
- FSM states IDLE, BUSY, DONE; counter `cnt` has MC_CNT_W bits.
- IDLE:
  - ex_mc_start with N = 0 is ignored: no stall, no done.
  - ex_mc_start with N = 1: EX stall this cycle, then go to DONE.
  - ex_mc_start with N ≥ 2: EX stall, cnt <= N-1, go to BUSY.
- BUSY:
  - EX stall; cnt <= cnt-1.
  - When cnt == 1, go to DONE.
  - The counter keeps running while a MEM stall overrides the encoding.
- DONE:
  - ex_mc_done = 1, no EX stall; ex_mc_start is ignored.
  - If mem_stallreq = 1: stay in DONE with ex_mc_done held high.
  - Otherwise go to IDLE next cycle.
- Result: total EX-level stall cycles for one op = N, excluding MEM-stall extension.
- id_stallreq is honoured only when no higher request is active. No state is kept for it.
- perf_stall_cnt increments on every cycle with ctrl_stall != 0 and saturates at 32'hFFFF_FFFF.

## Timing

- Reset (rst = 0 at edge) gives:
  - ctrl_stall = 0, ctrl_flush = 0, ex_mc_done = 0, perf_stall_cnt = 0, mem_timeout = 0.
  - FSM = IDLE, cnt = 0, timeout counter = 0.
  - While rst is low, combinational outputs are forced to 0.
- Reset mid-BUSY aborts the op; no ex_mc_done is produced.
- Zero-cycle response: a request raised in cycle t shows on ctrl_stall in cycle t.
- Multi-cycle op starting at cycle t with N: stall in cycles t..t+N-1, ex_mc_done in cycle t+N (if no MEM stall).
- Flush and ex_mc_start in the same cycle: flush wins; the FSM stays in IDLE.
- ex_flushreq during DONE: ex_mc_done = 0 that cycle, FSM goes to IDLE.

## Configuration

- `PIPE_CTRL_MEM_TIMEOUT_EN` defined:
  - A timeout counter counts consecutive mem_stallreq cycles and clears on any cycle with mem_stallreq = 0.
  - When the count reaches MEM_TIMEOUT, mem_timeout is set and stays set until reset.
  - Stalling is unaffected.
- Not defined: no timeout counter is built; mem_timeout is tied to 0.

## Test plan

- Reset with rst = 0 for 2 cycles while all requests are high -> all outputs 0; first cycle after release with id_stallreq = 1 -> ctrl_stall = 6'b000111.
- ex_mc_start with N = 4 at cycle 10 -> ctrl_stall = 6'b001111 in cycles 10–13, ex_mc_done = 1 in cycle 14, perf_stall_cnt = 4.
- N = 5; mem_stallreq high cycles 12–16 -> stall 6'b011111 in 12–16, ex_mc_done held high in 15–16 and still asserted in 17 with stall 0, FSM back in IDLE at 18.
- ex_flushreq in cycle 2 of a BUSY op with N = 8 -> ctrl_flush = 1, ctrl_stall = 0 that cycle, no ex_mc_done afterward; a new op with N = 1 then completes normally.
- With `PIPE_CTRL_MEM_TIMEOUT_EN` and MEM_TIMEOUT = 4: mem_stallreq high for 3 cycles, low 1, high 4 -> mem_timeout rises after the 4th consecutive cycle and stays 1.
- Without `PIPE_CTRL_MEM_TIMEOUT_EN`: same stimulus -> mem_timeout stays 0; perf_stall_cnt = 7.
